ahb_subordinate_mem: RTL and testbench
======================================

# ahb_subordinate_mem

AHB 2.0 subordinate with an internal word-organised memory, programmable wait states and a two-cycle ERROR response. It is the responder end of the bus driven by the AHB manager. It serves as the bench target for manager regressions and as a simple on-chip RAM in small systems. It uses the `t_htrans`, `t_hsize`, `t_hburst` and `t_hresp` types from `ahb_manager_pack`.

## Interface
- `DATA_WDT`, 32: data bus width; 32 or 64.
- `DEPTH`, 1024: memory depth in `DATA_WDT`-bit words.
- `WAIT_CYCLES`, 0: wait states per OKAY transfer; range 0..15.
- `BASE_ADDR`, 32'h0: byte address of word 0.

- `i_hclk`, input, 1: clock.
- `i_hreset_n`, input, 1: reset; asynchronous assert, active-low.
- `i_hsel`, input, 1: subordinate select, from the decoder.
- `i_haddr`, input, 32: byte address.
- `i_htrans`, input, `t_htrans`: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `i_hwrite`, input, 1: 1 = write.
- `i_hsize`, input, `t_hsize`: 0=byte, 1=half, 2=word, 3=dword.
- `i_hburst`, input, `t_hburst`: accepted but ignored, because every beat carries its own address.
- `i_hwdata`, input, `DATA_WDT`: write data, sampled in the data phase.
- `i_hready`, input, 1: global HREADY, which qualifies the address phase.
- `o_hreadyout`, output, 1: this subordinate's HREADY.
- `o_hresp`, output, `t_hresp`: OKAY=0 or ERROR=1 only. RETRY and SPLIT are never driven.
- `o_hrdata`, output, `DATA_WDT`: read data.

## Operation
**Address phase accept**
- An address phase is accepted on a rising edge when `i_hsel & i_hready & i_htrans[1]`, i.e. NONSEQ or SEQ.
- On accept, the block latches addr, write, size and offset.
- IDLE, BUSY or an unselected cycle with `i_hready=1` puts the block in ST_IDLE.

**Error check (at accept)**
- A transfer is an error if any of these hold:
  - `addr - BASE_ADDR >= DEPTH*DATA_WDT/8`;
  - the address is misaligned for its size, i.e. `addr & ((1<<size)-1) != 0`;
  - `(8<<size) > DATA_WDT`.
- An errored write never modifies memory.
- An errored read returns `o_hrdata` = 0.

**State machine**
- ST_IDLE: `hreadyout=1`, OKAY.
- On a good accept:
  - with `WAIT_CYCLES=0`, remain in ST_IDLE, so the next cycle is a zero-wait data phase;
  - otherwise go to ST_WAIT with `cnt=WAIT_CYCLES`.
- ST_WAIT: `hreadyout=0`, OKAY. Decrement `cnt`; when `cnt==1`, go to ST_IDLE, so the last data-phase cycle has `hreadyout=1`.
- An errored accept goes to ST_ERR1. Wait states never precede an ERROR.
- ST_ERR1: `hreadyout=0`, resp=ERROR, then go to ST_ERR2.
- ST_ERR2: `hreadyout=1`, resp=ERROR.
  - An accept in ST_ERR2 is processed normally.
  - Otherwise return to ST_IDLE.
- Accept is only possible when `i_hready=1`. Because the global HREADY mirrors this block's ready during its own data phase, no accept occurs in ST_WAIT or ST_ERR1.

**Memory**
- Word index: `(addr - BASE_ADDR) >> log2(DATA_WDT/8)`.
- Byte lanes are little-endian. Lane enable covers `(1<<size)` bytes starting at `addr[log2(DATA_WDT/8)-1:0]`.
- Writes commit on the edge that completes the data phase (`hreadyout=1`), using `i_hwdata` on the enabled lanes only.
- Reads:
  - The memory is read when the data phase completes, or at accept when `WAIT_CYCLES=0`.
  - `o_hrdata` is registered and carries the full word.
  - Lanes outside the transfer size return memory contents and are not zeroed.
- Read-after-write: if a read accept coincides with the completion of a write to the same word, the read returns the merged new data (forwarding).
- Memory is not reset. The bench must write a location before reading it.

## Timing
- Reset values: `o_hreadyout=1`, `o_hresp=OKAY`, `o_hrdata=0`, state ST_IDLE, `cnt=0`.
- Reset asserted mid-transfer aborts it: any pending write is dropped and outputs return to their reset values asynchronously.
- Zero-wait: accept on edge N. The data phase is cycle N→N+1 with `hreadyout=1`, and read data is valid in that same cycle.
- `WAIT_CYCLES=W`: `hreadyout=0` for exactly W cycles after accept, then 1 for one cycle. Read data is valid in the `hreadyout=1` cycle.
- ERROR: exactly two cycles, `{0,ERROR}` then `{1,ERROR}`.
- Back-to-back pipelined transfers sustain one beat per `W+1` cycles.
- `o_hrdata` holds its last value when no read completes.

## Test plan
- **Zero-wait pipeline.** `WAIT_CYCLES=0`: NONSEQ write 32'hDEADBEEF @0x10, then SEQ read @0x10 on the next cycle → forwarded read returns 32'hDEADBEEF; `hreadyout` stays 1 throughout.
- **Wait states.** `WAIT_CYCLES=3`: read @0x4 (preloaded 32'h12345678) → `hreadyout` is 0,0,0,1; data 32'h12345678 in the 4th cycle; resp OKAY.
- **Byte lanes.** Byte write 8'hAA @0x21 to a word holding 32'h00000000 → word read @0x20 returns 32'h0000AA00. Half write 16'h5555 @0x22 → word reads 32'h5555AA00.
- **Error, misaligned.** Word write @0x22 → `{hreadyout,hresp}` = `{0,ERROR}`, `{1,ERROR}`; a subsequent read @0x20 returns its prior contents unchanged.
- **Error, out of range, with a following transfer.** Read @`BASE_ADDR+DEPTH*4` → two-cycle ERROR with `o_hrdata=0`; a NONSEQ read @0x0 issued in ST_ERR2 completes OKAY.
- **Filler and reset.** IDLE/BUSY or `hsel=0` cycles → OKAY, `hreadyout=1`, memory untouched. Reset asserted during ST_WAIT → `hreadyout=1`, OKAY immediately, pending write not committed.

Source files
------------

// File: rtl/ahb_subordinate_mem.sv
// Shared AHB type package and an AHB 2.0 subordinate backed by a word-organised RAM,
// with programmable wait states and a two-cycle ERROR response.
package ahb_manager_pack;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } t_htrans;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } t_hsize;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } t_hresp;
endpackage

module ahb_subordinate_mem
  import ahb_manager_pack::*;
#(
  parameter int unsigned DATA_WDT    = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  logic [31:0]         i_haddr,
  input  t_htrans             i_htrans,
  input  logic                i_hwrite,
  input  t_hsize              i_hsize,
  input  t_hburst             i_hburst,
  input  logic [DATA_WDT-1:0] i_hwdata,
  input  logic                i_hready,
  output logic                o_hreadyout,
  output t_hresp              o_hresp,
  output logic [DATA_WDT-1:0] o_hrdata
);

  localparam int unsigned BYTES     = DATA_WDT / 8;
  localparam int unsigned LSB       = $clog2(BYTES);
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH * BYTES);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} t_state;

  t_state               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;

  logic [1:0]           trans;
  logic [2:0]           size;
  logic [31:0]          off;
  logic [31:0]          align_mask;
  logic [10:0]          size_bits;
  logic [31:0]          lane;
  logic [31:0]          nbytes;
  logic                 accept;
  logic                 acc_err;
  logic [IDX_W-1:0]     acc_idx;
  logic [BYTES-1:0]     acc_be;

  logic                 dp_valid;
  logic                 dp_write;
  logic                 dp_err;
  logic [IDX_W-1:0]     dp_idx;
  logic [BYTES-1:0]     dp_be;
  logic                 dp_done;
  logic                 wr_commit;

  logic [DATA_WDT-1:0]  mem [DEPTH];
  logic [DATA_WDT-1:0]  fwd_word;
  logic                 unused;

  assign trans  = i_htrans;
  assign size   = i_hsize;
  assign unused = ^{i_hburst, trans[0]};

  // Address-phase decode: error classification, word index and byte-lane enables.
  always_comb begin
    off        = i_haddr - BASE_ADDR;
    align_mask = (32'd1 << size) - 32'd1;
    size_bits  = 11'(11'd8 << size);
    lane       = 32'(i_haddr[LSB-1:0]);
    nbytes     = 32'd1 << size;
    acc_err    = ({1'b0, off} >= MEM_BYTES) ||
                 ((i_haddr & align_mask) != 32'd0) ||
                 (32'(size_bits) > DATA_WDT);
    acc_idx    = IDX_W'(off >> LSB);
    for (int unsigned i = 0; i < BYTES; i++) begin
      acc_be[i] = (i >= lane) && (i < lane + nbytes);
    end
  end

  // Accepts are only honoured while this block is itself ready.
  assign accept    = i_hsel & i_hready & trans[1] & o_hreadyout;
  assign dp_done   = o_hreadyout & dp_valid;
  assign wr_commit = dp_done & dp_write & ~dp_err;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin : state_reg
    if (!i_hreset_n) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 4'd0;
        if (accept) begin
          if (acc_err) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_INIT != 4'd0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ST_IDLE;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin : outputs
    o_hreadyout = 1'b1;
    o_hresp     = HRESP_OKAY;
    unique case (state)
      ST_WAIT: o_hreadyout = 1'b0;
      ST_ERR1: begin
        o_hreadyout = 1'b0;
        o_hresp     = HRESP_ERROR;
      end
      ST_ERR2: o_hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Data-phase context captured at accept; retired when the data phase completes.
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin : data_phase
    if (!i_hreset_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_err   <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
    end else if (accept) begin
      dp_valid <= 1'b1;
      dp_write <= i_hwrite;
      dp_err   <= acc_err;
      dp_idx   <= acc_idx;
      dp_be    <= acc_be;
    end else if (dp_done) begin
      dp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_hclk) begin : mem_write
    if (wr_commit) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (dp_be[i]) mem[dp_idx][8*i +: 8] <= i_hwdata[8*i +: 8];
      end
    end
  end

  // Zero-wait reads see a write completing on the same edge to the same word.
  always_comb begin
    for (int unsigned i = 0; i < BYTES; i++) begin
      fwd_word[8*i +: 8] = (wr_commit && (dp_idx == acc_idx) && dp_be[i]) ?
                           i_hwdata[8*i +: 8] : mem[acc_idx][8*i +: 8];
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin : read_data
    if (!i_hreset_n) begin
      o_hrdata <= '0;
    end else if (accept && !i_hwrite) begin
      if (acc_err) begin
        o_hrdata <= '0;
      end else if (WAIT_INIT == 4'd0) begin
        o_hrdata <= fwd_word;
      end
    end else if ((state == ST_WAIT) && (cnt == 4'd1) && dp_valid && !dp_write) begin
      o_hrdata <= mem[dp_idx];
    end
  end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Bench for ahb_subordinate_mem: a zero-wait and a three-wait instance checked against
// a byte-addressed memory model plus directed pipeline, error and reset sequences.
module tb_ahb_subordinate_mem;
  import ahb_manager_pack::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned MEMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  t_htrans     htrans;
  logic        hwrite;
  t_hsize      hsize;
  t_hburst     hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        ready0, ready1;
  t_hresp      resp0, resp1;
  logic [31:0] rdata0, rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mdl [2][MEMB];

  typedef struct {
    int          dev;
    logic        wr;
    logic [31:0] addr;
    int          size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [16];

  always #5 clk = ~clk;

  // Idle subordinates drive ready high, so the AND mirrors the active data phase.
  assign hready = ready0 & ready1;

  ahb_subordinate_mem #(.DATA_WDT(32), .DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_mem0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[0]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata), .i_hready(hready),
    .o_hreadyout(ready0), .o_hresp(resp0), .o_hrdata(rdata0));

  ahb_subordinate_mem #(.DATA_WDT(32), .DEPTH(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(32'h0)) u_mem3 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel[1]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata), .i_hready(hready),
    .o_hreadyout(ready1), .o_hresp(resp1), .o_hrdata(rdata1));

  function automatic logic get_ready(input int dev);
    return (dev == 0) ? ready0 : ready1;
  endfunction

  function automatic t_hresp get_resp(input int dev);
    return (dev == 0) ? resp0 : resp1;
  endfunction

  function automatic logic [31:0] get_rdata(input int dev);
    return (dev == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic mdl_err(input logic [31:0] addr, input int size);
    logic [31:0] span;
    span = 32'd1 << size;
    return (addr >= MEMB) || ((addr % span) != 32'd0) || ((8 << size) > 32);
  endfunction

  function automatic logic [31:0] mdl_word(input int dev, input logic [31:0] addr);
    int b;
    b = int'(addr & 32'h0000_0FFC);
    return {mdl[dev][b+3], mdl[dev][b+2], mdl[dev][b+1], mdl[dev][b]};
  endfunction

  task automatic mdl_write(input int dev, input logic [31:0] addr, input int size,
                           input logic [31:0] wdata);
    int a;
    for (int k = 0; k < (1 << size); k++) begin
      a = int'(addr) + k;
      mdl[dev][a] = wdata[8*(a % 4) +: 8];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    hsel   = 2'b00;
    htrans = HTRANS_IDLE;
  endtask

  // One isolated transfer; called and returns on a falling edge.
  task automatic xfer(input int dev, input logic wr, input logic [31:0] addr, input int size,
                      input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rd,
                      input string tag);
    int waits;
    int budget;
    hsel      = 2'b00;
    hsel[dev] = 1'b1;
    htrans    = HTRANS_NONSEQ;
    hwrite    = wr;
    haddr     = addr;
    hsize     = t_hsize'(size);
    hburst    = HBURST_SINGLE;
    @(negedge clk);
    idle_bus();
    hwdata = wdata;
    waits  = 0;
    budget = 20;
    while (get_ready(dev) == 1'b0 && budget > 0) begin
      check({tag, " wait resp"}, 32'(get_resp(dev)),
            exp_err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
      waits++;
      budget--;
      @(negedge clk);
    end
    check({tag, " low cycles"}, 32'(waits), exp_err ? 32'd1 : ((dev == 0) ? 32'd0 : 32'd3));
    check({tag, " resp"}, 32'(get_resp(dev)), exp_err ? 32'(HRESP_ERROR) : 32'(HRESP_OKAY));
    if (!wr) check({tag, " rdata"}, get_rdata(dev), exp_err ? 32'd0 : exp_rd);
    @(negedge clk);
    if (wr && !exp_err) mdl_write(dev, addr, size, wdata);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] a, wd, old8;
    int dev, sz;
    logic wr;

    tbl[0]  = '{1, 1'b1, 32'h04,   2, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b0, 32'h04,   2, 32'h0,         1'b0, 32'h1234_5678};
    tbl[2]  = '{0, 1'b1, 32'h20,   2, 32'h0,         1'b0, 32'h0};
    tbl[3]  = '{0, 1'b1, 32'h21,   0, 32'h0000_AA00, 1'b0, 32'h0};
    tbl[4]  = '{0, 1'b0, 32'h20,   2, 32'h0,         1'b0, 32'h0000_AA00};
    tbl[5]  = '{0, 1'b1, 32'h22,   1, 32'h5555_0000, 1'b0, 32'h0};
    tbl[6]  = '{0, 1'b0, 32'h20,   2, 32'h0,         1'b0, 32'h5555_AA00};
    tbl[7]  = '{0, 1'b1, 32'h22,   2, 32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[8]  = '{0, 1'b0, 32'h20,   2, 32'h0,         1'b0, 32'h5555_AA00};
    tbl[9]  = '{0, 1'b0, 32'h1000, 2, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{0, 1'b0, 32'h00,   3, 32'h0,         1'b1, 32'h0};
    tbl[11] = '{1, 1'b0, 32'h1000, 2, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{1, 1'b0, 32'h04,   0, 32'h0,         1'b0, 32'h1234_5678};
    tbl[13] = '{1, 1'b1, 32'h06,   1, 32'hABCD_0000, 1'b0, 32'h0};
    tbl[14] = '{1, 1'b0, 32'h04,   2, 32'h0,         1'b0, 32'hABCD_5678};
    tbl[15] = '{1, 1'b1, 32'h03,   1, 32'hFFFF_FFFF, 1'b1, 32'h0};

    rst_n  = 1'b0;
    idle_bus();
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = HSIZE_WORD;
    hburst = HBURST_SINGLE;
    hwdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset ready0", 32'(ready0), 32'd1);
    check("reset resp0", 32'(resp0), 32'(HRESP_OKAY));
    check("reset rdata0", rdata0, 32'd0);
    check("reset ready1", 32'(ready1), 32'd1);
    check("reset resp1", 32'(resp1), 32'(HRESP_OKAY));
    check("reset rdata1", rdata1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      xfer(tbl[i].dev, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata,
           tbl[i].err, tbl[i].rd, $sformatf("vec%0d", i));
    end

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        xfer(d, 1'b1, 32'(w * 4), 2, $urandom, 1'b0, 32'h0, $sformatf("init%0d_%0d", d, w));
      end
    end

    for (int i = 0; i < 80; i++) begin
      dev = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      sz  = int'($urandom_range(0, 3));
      a   = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 15))
                                        : 32'($urandom_range(0, 63));
      wd  = $urandom;
      xfer(dev, wr, a, sz, wd, mdl_err(a, sz), mdl_word(dev, a), $sformatf("rnd%0d", i));
    end

    // Zero-wait pipeline: write then read of the same word on consecutive beats.
    hsel = 2'b01; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h10;
    hsize = HSIZE_WORD; hburst = HBURST_INCR;
    @(negedge clk);
    check("pipe wr ready", 32'(ready0), 32'd1);
    hwdata = 32'hDEAD_BEEF; htrans = HTRANS_SEQ; hwrite = 1'b0;
    @(negedge clk);
    idle_bus();
    check("pipe rd ready", 32'(ready0), 32'd1);
    check("pipe rd resp", 32'(resp0), 32'(HRESP_OKAY));
    check("pipe rd fwd data", rdata0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("pipe end ready", 32'(ready0), 32'd1);
    mdl_write(0, 32'h10, 2, 32'hDEAD_BEEF);

    // Filler cycles must leave memory and read data untouched.
    hwdata = 32'h1111_1111; hwrite = 1'b1; haddr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      hsel   = (i == 2) ? 2'b00 : 2'b01;
      htrans = (i == 0) ? HTRANS_IDLE : ((i == 1) ? HTRANS_BUSY : HTRANS_NONSEQ);
      @(negedge clk);
      check($sformatf("filler%0d ready", i), 32'(ready0), 32'd1);
      check($sformatf("filler%0d resp", i), 32'(resp0), 32'(HRESP_OKAY));
      check($sformatf("filler%0d rdata hold", i), rdata0, 32'hDEAD_BEEF);
    end
    idle_bus();
    @(negedge clk);
    xfer(0, 1'b0, 32'h10, 2, 32'h0, 1'b0, mdl_word(0, 32'h10), "filler readback");

    // Out-of-range read followed by a read accepted during the second ERROR cycle.
    hsel = 2'b01; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h1000; hsize = HSIZE_WORD;
    @(negedge clk);
    check("oor err1 ready", 32'(ready0), 32'd0);
    check("oor err1 resp", 32'(resp0), 32'(HRESP_ERROR));
    check("oor err1 rdata", rdata0, 32'd0);
    haddr = 32'h0;
    @(negedge clk);
    check("oor err2 ready", 32'(ready0), 32'd1);
    check("oor err2 resp", 32'(resp0), 32'(HRESP_ERROR));
    @(negedge clk);
    idle_bus();
    check("after err ready", 32'(ready0), 32'd1);
    check("after err resp", 32'(resp0), 32'(HRESP_OKAY));
    check("after err rdata", rdata0, mdl_word(0, 32'h0));
    @(negedge clk);

    // Reset during wait states drops the pending write.
    old8 = mdl_word(1, 32'h8);
    hsel = 2'b10; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h8; hsize = HSIZE_WORD;
    @(negedge clk);
    idle_bus();
    hwdata = ~old8;
    check("rst wait ready", 32'(ready1), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst async ready", 32'(ready1), 32'd1);
    check("rst async resp", 32'(resp1), 32'(HRESP_OKAY));
    check("rst async rdata", rdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 1'b0, 32'h8, 2, 32'h0, 1'b0, old8, "rst dropped write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
